// File: rtl/width_conv_pkg.sv
// rtl/width_conv_pkg.sv - shared widths and types for the 64-to-8 width converter
package width_conv_pkg;

    localparam int DIN_W  = 64;
    localparam int DOUT_W = 8;
    localparam int BPW    = DIN_W / DOUT_W;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDX_W  = $clog2(BPW);

    typedef logic [DIN_W-1:0]  word_t;
    typedef logic [DOUT_W-1:0] byte_t;
    typedef logic [IDX_W-1:0]  idx_t;

    localparam idx_t LAST_IDX = idx_t'(BPW - 1);

    // Little-endian byte select: byte k occupies word[8k+7:8k]
    function automatic byte_t pick_byte(input word_t w, input idx_t k);
        return w[k*DOUT_W +: DOUT_W];
    endfunction

endpackage

// File: rtl/sync_fifo_w.sv
// rtl/sync_fifo_w.sv - single-clock word FIFO with occupancy count
module sync_fifo_w
    import width_conv_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  word_t            din,
    input  logic             pop,
    output word_t            dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    word_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered count, so a same-cycle pop never frees a slot
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally; count tracks push/pop, net zero when both happen
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/module_64_to_8.sv
// rtl/module_64_to_8.sv - buffers 64-bit words and hands them out one byte per request
module module_64_to_8
    import width_conv_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              strobe_in,
    input  logic [DIN_W-1:0]  input_data,
    input  logic              req_data,
    output logic              ready,
    output logic              data_end,
    output logic              strobe_out,
    output logic [DOUT_W-1:0] data_out
);

    word_t            fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_push;
    logic             fifo_load;

    word_t cur_word;
    logic  cur_valid;
    idx_t  byte_idx;
    logic  rd_accept;
    logic  last_byte;

    assign fifo_push = strobe_in && !fifo_full;
    assign rd_accept = req_data && cur_valid;
    assign last_byte = (byte_idx == LAST_IDX);
    // Load when idle, or when the final byte leaves so the next word follows with no bubble
    assign fifo_load = !fifo_empty && (!cur_valid || (rd_accept && last_byte));
    assign ready     = cur_valid;

    sync_fifo_w u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .din     (input_data),
        .pop     (fifo_load),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Serializer: current word, its valid flag and the index of the next byte to send
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_word  <= '0;
            cur_valid <= 1'b0;
            byte_idx  <= '0;
        end else if (fifo_load) begin
            cur_word  <= fifo_head;
            cur_valid <= 1'b1;
            byte_idx  <= '0;
        end else if (rd_accept) begin
            byte_idx <= byte_idx + 1'b1;
            if (last_byte) begin
                cur_valid <= 1'b0;
            end
        end
    end

    // Registered byte output; data_end marks the final byte when nothing is left behind it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            strobe_out <= 1'b0;
            data_end   <= 1'b0;
            data_out   <= '0;
        end else begin
            strobe_out <= rd_accept;
            data_end   <= rd_accept && last_byte && (fifo_count == '0);
            if (rd_accept) begin
                data_out <= pick_byte(cur_word, byte_idx);
            end
        end
    end

endmodule

// File: tb/tb_module_64_to_8.sv
// tb/tb_module_64_to_8.sv - table and scoreboard bench for module_64_to_8
module tb_module_64_to_8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        strobe_in;
    logic [63:0] input_data;
    logic        req_data;
    logic        ready;
    logic        data_end;
    logic        strobe_out;
    logic [7:0]  data_out;

    typedef struct {
        logic [63:0] word;
        bit          accept;
        bit          last;
    } vec_t;

    typedef struct {
        logic [7:0] b;
        bit         e;
    } exp_t;

    vec_t tbl [19];
    exp_t exp_q [$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   stb_total = 0;
    int   first_stb = -1;
    int   last_stb = -1;
    bit   init_done = 0;

    module_64_to_8 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .strobe_in  (strobe_in),
        .input_data (input_data),
        .req_data   (req_data),
        .ready      (ready),
        .data_end   (data_end),
        .strobe_out (strobe_out),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_word(input logic [63:0] w, input bit last);
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            e.b = w[8*k +: 8];
            e.e = last && (k == 7);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: every strobe pops the next expected byte
    always @(negedge clk) begin
        exp_t e;
        if (init_done) begin
            if (strobe_out === 1'b1) begin
                stb_total++;
                if (first_stb < 0) first_stb = cyc;
                last_stb = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {56'd0, data_out}, 64'hXX);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", {56'd0, data_out}, {56'd0, e.b});
                    check("data_end", {63'd0, data_end}, {63'd0, e.e});
                end
            end else if (data_end !== 1'b0) begin
                check("end_without_strobe", {63'd0, data_end}, 64'd0);
            end
        end
    end

    task automatic write_word(input logic [63:0] w);
        @(posedge clk); #1;
        strobe_in  = 1'b1;
        input_data = w;
    endtask

    task automatic end_write();
        @(posedge clk); #1;
        strobe_in = 1'b0;
    endtask

    task automatic drain(input bit lag, input int bound);
        int  n = 0;
        bit  last_r = 1'b0;
        while (exp_q.size() > 0 && n < bound) begin
            @(posedge clk); #1;
            if (lag) begin
                req_data = last_r;
                last_r   = ready;
            end else begin
                req_data = 1'b1;
            end
            @(negedge clk); #1;
            n++;
        end
        req_data = 1'b0;
        check("drain_complete", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] burst [16];
        logic [63:0] short_w [4];
        int          base;
        int          n;

        tbl[0] = '{64'h0807060504030201, 1'b1, 1'b1};
        for (int i = 1; i < 19; i++) begin
            tbl[i].word   = {$urandom, $urandom};
            // one word sits in the serializer, sixteen in the FIFO; the 18th finds it full
            tbl[i].accept = (i <= 17);
            tbl[i].last   = (i == 17);
        end

        reset_n    = 1'b0;
        strobe_in  = 1'b0;
        input_data = '0;
        req_data   = 1'b0;

        // 1: outputs stay cleared while reset is held
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); #1;
            init_done = 1;
            check("rst_ready", {63'd0, ready}, 64'd0);
            check("rst_strobe_out", {63'd0, strobe_out}, 64'd0);
            check("rst_data_end", {63'd0, data_end}, 64'd0);
            check("rst_data_out", {56'd0, data_out}, 64'd0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;

        // 2: single known word with request held high
        req_data = 1'b1;
        write_word(tbl[0].word);
        push_word(tbl[0].word, tbl[0].last);
        end_write();
        drain(1'b0, 50);
        check("t2_ready_low", {63'd0, ready}, 64'd0);

        // 3: 16-word burst, request follows ready one cycle late
        for (int i = 0; i < 16; i++) begin
            burst[i] = {$urandom, $urandom};
            push_word(burst[i], i == 15);
        end
        first_stb = -1;
        base = stb_total;
        fork
            begin
                for (int i = 0; i < 16; i++) write_word(burst[i]);
                end_write();
            end
            drain(1'b1, 400);
        join
        check("t3_strobe_count", 64'(stb_total - base), 64'd128);
        check("t3_no_gaps", 64'(last_stb - first_stb), 64'd127);

        // 4: overfill with no reads, then drain
        base = stb_total;
        for (int i = 1; i < 19; i++) begin
            write_word(tbl[i].word);
            if (tbl[i].accept) push_word(tbl[i].word, tbl[i].last);
        end
        end_write();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("t4_ready_high", {63'd0, ready}, 64'd1);
        check("t4_no_strobes", 64'(stb_total - base), 64'd0);
        drain(1'b0, 300);
        check("t4_ready_low", {63'd0, ready}, 64'd0);

        // 5: requests while empty are ignored and data_out holds
        req_data = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check("t5_no_strobe", {63'd0, strobe_out}, 64'd0);
            check("t5_data_hold", {56'd0, data_out}, {56'd0, tbl[17].word[63:56]});
        end
        req_data = 1'b0;

        // 6: reset in the middle of a 4-word stream
        for (int i = 0; i < 4; i++) begin
            short_w[i] = {$urandom, $urandom};
            push_word(short_w[i], i == 3);
        end
        base = stb_total;
        req_data = 1'b1;
        for (int i = 0; i < 4; i++) write_word(short_w[i]);
        end_write();
        n = 0;
        while (stb_total < base + 20 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        req_data = 1'b0;
        reset_n  = 1'b0;
        check("t6_bytes_before_reset", 64'(stb_total - base), 64'd20);
        @(negedge clk); #1;
        exp_q.delete();
        check("t6_ready_cleared", {63'd0, ready}, 64'd0);
        check("t6_strobe_cleared", {63'd0, strobe_out}, 64'd0);
        check("t6_end_cleared", {63'd0, data_end}, 64'd0);
        check("t6_data_cleared", {56'd0, data_out}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        base = stb_total;
        req_data = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("t6_no_strobes_after_reset", 64'(stb_total - base), 64'd0);
        check("t6_ready_after_reset", {63'd0, ready}, 64'd0);
        req_data = 1'b0;
        write_word(64'hF0E1D2C3B4A59687);
        push_word(64'hF0E1D2C3B4A59687, 1'b1);
        end_write();
        drain(1'b0, 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
